// File: rtl/adc_lane_bitslip_align.sv
// Per-lane word aligner: slips each ISERDES lane until its word matches the
// training pattern, reports lock per lane, and forwards din with one register stage.
module adc_lane_bitslip_align #(
  parameter int                   DATA_WIDTH = 10,
  parameter int                   SER_RATIO  = 8,
  parameter logic [SER_RATIO-1:0] PATTERN    = 8'hA5,
  parameter int                   SETTLE_CYC = 8,
  parameter int                   MATCH_CYC  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            train_start,
  input  logic [DATA_WIDTH*SER_RATIO-1:0] din,
  output logic [DATA_WIDTH-1:0]           bitslip,
  output logic [DATA_WIDTH-1:0]           lane_locked,
  output logic                            busy,
  output logic                            done,
  output logic                            fail,
  output logic [DATA_WIDTH*SER_RATIO-1:0] dout,
  output logic                            dout_valid
);

  // state  | meaning
  // IDLE   | waiting for train_start
  // SETTLE | letting ISERDES output settle after a start or slip
  // CHECK  | counting consecutive pattern matches per unlocked lane
  // SLIP   | one-cycle bitslip pulse on every unlocked lane
  // DONE   | all lanes locked, data valid
  // FAIL   | some unlocked lane ran out of slips
  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, DONE, FAIL} state_t;

  localparam int TMR_MAX = (SETTLE_CYC > MATCH_CYC) ? SETTLE_CYC : MATCH_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int MCH_W   = $clog2(MATCH_CYC + 1);
  localparam int SLIP_W  = $clog2(SER_RATIO + 1);

  localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0]  MATCH_LOAD  = TMR_W'(MATCH_CYC - 1);
  localparam logic [MCH_W-1:0]  MATCH_DONE  = MCH_W'(MATCH_CYC);
  localparam logic [SLIP_W-1:0] SLIP_MAX    = SLIP_W'(SER_RATIO);

  state_t              state;
  logic [TMR_W-1:0]    timer;
  logic [MCH_W-1:0]    match_cnt [DATA_WIDTH];
  logic [SLIP_W-1:0]   slip_cnt  [DATA_WIDTH];

  logic [MCH_W-1:0]    cnt_next  [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] locked_next;
  logic [DATA_WIDTH-1:0] exhausted;

  // Lock decision for the final CHECK cycle includes this cycle's compare.
  always_comb begin
    locked_next = lane_locked;
    exhausted   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt_next[i] = '0;
      if (din[i*SER_RATIO +: SER_RATIO] == PATTERN)
        cnt_next[i] = match_cnt[i] + MCH_W'(1);
      if (!lane_locked[i] && cnt_next[i] == MATCH_DONE)
        locked_next[i] = 1'b1;
      exhausted[i] = !locked_next[i] && (slip_cnt[i] == SLIP_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      bitslip     <= '0;
      lane_locked <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        match_cnt[i] <= '0;
        slip_cnt[i]  <= '0;
      end
    end else begin
      dout    <= din;
      bitslip <= '0;
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (train_start) begin
            state       <= SETTLE;
            timer       <= SETTLE_LOAD;
            busy        <= 1'b1;
            done        <= 1'b0;
            fail        <= 1'b0;
            dout_valid  <= 1'b0;
            lane_locked <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
              match_cnt[i] <= '0;
              slip_cnt[i]  <= '0;
            end
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            state <= CHECK;
            timer <= MATCH_LOAD;
            for (int i = 0; i < DATA_WIDTH; i++) match_cnt[i] <= '0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        CHECK: begin
          for (int i = 0; i < DATA_WIDTH; i++) match_cnt[i] <= cnt_next[i];
          if (timer != '0) begin
            timer <= timer - TMR_W'(1);
          end else begin
            lane_locked <= locked_next;
            if (&locked_next) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              dout_valid <= 1'b1;
            end else if (|exhausted) begin
              state <= FAIL;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end else begin
              state   <= SLIP;
              bitslip <= ~locked_next;
              for (int i = 0; i < DATA_WIDTH; i++)
                if (!locked_next[i]) slip_cnt[i] <= slip_cnt[i] + SLIP_W'(1);
            end
          end
        end
        SLIP: begin
          state <= SETTLE;
          timer <= SETTLE_LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
